// File: rtl/sum4_splitter_pkg.sv
// Shared types, constants and range check for the total-to-nibble splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sum4_splitter_pkg;

    localparam int DEF_NIB_W   = 4;
    localparam int DEF_N_NIB   = 4;
    localparam int DEF_IDX_W   = $clog2(DEF_N_NIB);
    localparam int DEF_TOT_W   = DEF_NIB_W + DEF_IDX_W;
    localparam int NMIN        = -(1 << (DEF_NIB_W - 1));
    localparam int NMAX        = (1 << (DEF_NIB_W - 1)) - 1;
    localparam int TOT_MIN     = DEF_N_NIB * NMIN;
    localparam int TOT_MAX     = DEF_N_NIB * NMAX;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // A total is splittable only if N nibbles, each saturated, can reach it.
    function automatic logic total_in_range(input int total, input int nib_w, input int n_nib);
        int lo;
        int hi;
        lo = n_nib * (-(1 << (nib_w - 1)));
        hi = n_nib * ((1 << (nib_w - 1)) - 1);
        return (total >= lo) && (total <= hi);
    endfunction

endpackage

// File: rtl/sum4_splitter_sat_clamp.sv
// Signed saturate from IN_W bits down to OUT_W bits.
// Latency: combinational.
// Backpressure: none.
module sat_clamp #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 4
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam int MAXI = (1 << (OUT_W - 1)) - 1;
    localparam int MINI = -(1 << (OUT_W - 1));

    logic signed [IN_W-1:0] max_v;
    logic signed [IN_W-1:0] min_v;

    assign max_v = IN_W'(MAXI);
    assign min_v = IN_W'(MINI);

    // Saturate to the output range, otherwise pass the low bits through.
    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > max_v) begin
            dout = max_v[OUT_W-1:0];
        end else if (din < min_v) begin
            dout = min_v[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/sum4_splitter.sv
// Splits one signed total into N_NIB greedily saturated signed nibbles, streamed and bundled.
// Latency: first beat the cycle after accept; done the cycle after the last beat.
// Backpressure: out_ready low holds the current beat; in_ready is low for the whole split.
module sum4_splitter
    import sum4_splitter_pkg::*;
#(
    parameter int NIB_W = DEF_NIB_W,
    parameter int N_NIB = DEF_N_NIB,
    parameter int IDX_W = $clog2(N_NIB),
    parameter int TOT_W = NIB_W + IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [TOT_W-1:0] in_total,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [NIB_W-1:0] out_nib,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    err,
    output logic                    done,
    output logic signed [NIB_W-1:0] nib_a,
    output logic signed [NIB_W-1:0] nib_b,
    output logic signed [NIB_W-1:0] nib_c,
    output logic signed [NIB_W-1:0] nib_d
);

    // One extra bit so the remainder never wraps while nibbles are subtracted.
    localparam int R_W = TOT_W + 1;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [R_W-1:0]   rem;
    logic [IDX_W-1:0]        idx;
    logic signed [NIB_W-1:0] bundle [N_NIB];
    logic                    legal;
    logic                    accept;
    logic                    reject;
    logic                    beat;

    sat_clamp #(
        .IN_W  (R_W),
        .OUT_W (NIB_W)
    ) u_clamp (
        .din  (rem),
        .dout (out_nib)
    );

    assign legal     = total_in_range(int'(in_total), NIB_W, N_NIB);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign out_idx   = idx;
    assign out_last  = (idx == IDX_W'(N_NIB - 1));
    assign accept    = in_ready && in_valid && legal;
    assign reject    = in_ready && in_valid && !legal;
    assign beat      = out_valid && out_ready;

    assign nib_a = bundle[0];
    assign nib_b = bundle[1];
    assign nib_c = bundle[2];
    assign nib_d = bundle[3];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave IDLE on a legal total, return after the last beat is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EMIT;
            EMIT:    if (beat && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Remainder, beat index, bundle slots and the err/done pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= '0;
            idx  <= '0;
            err  <= 1'b0;
            done <= 1'b0;
            for (int i = 0; i < N_NIB; i++) begin
                bundle[i] <= '0;
            end
        end else begin
            err  <= reject;
            done <= beat && out_last;
            if (accept) begin
                rem <= {in_total[TOT_W-1], in_total};
                idx <= '0;
            end else if (beat) begin
                bundle[idx] <= out_nib;
                rem         <= rem - {{(R_W-NIB_W){out_nib[NIB_W-1]}}, out_nib};
                // Wraps to zero after the last beat since N_NIB is a power of two.
                idx         <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sum4_splitter.sv
module tb_sum4_splitter;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic signed [5:0] in_total;
    logic              out_valid;
    logic              out_ready;
    logic signed [3:0] out_nib;
    logic [1:0]        out_idx;
    logic              out_last;
    logic              err;
    logic              done;
    logic signed [3:0] nib_a;
    logic signed [3:0] nib_b;
    logic signed [3:0] nib_c;
    logic signed [3:0] nib_d;

    int checks;
    int failures;

    sum4_splitter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_total  (in_total),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_nib   (out_nib),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err       (err),
        .done      (done),
        .nib_a     (nib_a),
        .nib_b     (nib_b),
        .nib_c     (nib_c),
        .nib_d     (nib_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bundle(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_a"}, int'(nib_a), a);
        chk({tag, "_b"}, int'(nib_b), b);
        chk({tag, "_c"}, int'(nib_c), c);
        chk({tag, "_d"}, int'(nib_d), d);
    endtask

    // Full split with out_ready held high; expected beats given explicitly.
    task automatic split(input string tag, input int total, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_total = 6'(total);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_vld"}, int'(out_valid), 1);
            chk({tag, "_nib"}, int'(out_nib), e[i]);
            chk({tag, "_idx"}, int'(out_idx), i);
            chk({tag, "_last"}, int'(out_last), (i == 3) ? 1 : 0);
            chk({tag, "_rdy_low"}, int'(in_ready), 0);
            chk({tag, "_done_early"}, int'(done), 0);
            tick();
        end
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_idle_rdy"}, int'(in_ready), 1);
        chk({tag, "_idle_vld"}, int'(out_valid), 0);
        chk_bundle(tag, e0, e1, e2, e3);
        tick();
        chk({tag, "_done_drop"}, int'(done), 0);
    endtask

    initial begin
        int pat [7];
        int ebp [4];
        int nb;
        int sum;
        int beats;
        int guard;
        int nv;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_total = '0;
        out_ready = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_done", int'(done), 0);
        chk_bundle("rst_bundle", 0, 0, 0, 0);

        split("t10", 10, 7, 3, 0, 0);

        // Reset in the middle of a split of 20 (beats 7,7,6,0).
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_total  = 6'(20);
        tick();
        in_valid = 1'b0;
        chk("mid_b0", int'(out_nib), 7);
        tick();
        chk("mid_b1", int'(out_nib), 7);
        tick();
        chk("mid_b2_idx", int'(out_idx), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", int'(out_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_post_vld", int'(out_valid), 0);
        chk("mid_post_rdy", int'(in_ready), 1);
        chk("mid_post_done", int'(done), 0);
        chk_bundle("mid_bundle", 0, 0, 0, 0);
        tick();
        chk("mid_post_vld2", int'(out_valid), 0);
        split("t5", 5, 5, 0, 0, 0);

        split("tm32", -32, -8, -8, -8, -8);
        split("t28", 28, 7, 7, 7, 7);
        split("tm1", -1, -1, 0, 0, 0);

        // Unrepresentable totals are rejected with a one-cycle err.
        for (int t = 29; t <= 31; t++) begin
            in_valid = 1'b1;
            in_total = 6'(t);
            tick();
            in_valid = 1'b0;
            chk("rej_err", int'(err), 1);
            chk("rej_vld", int'(out_valid), 0);
            chk("rej_rdy", int'(in_ready), 1);
            tick();
            chk("rej_err_drop", int'(err), 0);
            chk("rej_vld2", int'(out_valid), 0);
            chk_bundle("rej_bundle", -1, 0, 0, 0);
        end
        split("tm9", -9, -8, -1, 0, 0);

        // Backpressure on -20: beats -8,-8,-4,0 with ready pattern 1,0,0,1,1,0,1.
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
        ebp[0] = -8; ebp[1] = -8; ebp[2] = -4; ebp[3] = 0;
        nb = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_total  = 6'(-20);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            out_ready = pat[c][0];
            chk("bp_vld", int'(out_valid), 1);
            chk("bp_nib", int'(out_nib), ebp[nb]);
            chk("bp_idx", int'(out_idx), nb);
            chk("bp_done_early", int'(done), 0);
            tick();
            if (pat[c] == 1) nb++;
        end
        out_ready = 1'b0;
        chk("bp_done", int'(done), 1);
        chk("bp_vld_end", int'(out_valid), 0);
        chk_bundle("bp_bundle", -8, -8, -4, 0);
        tick();
        chk("bp_done_once", int'(done), 0);
        chk("bp_no_extra", int'(out_valid), 0);

        // Scoreboard: every legal total splits into in-range nibbles summing to it.
        out_ready = 1'b1;
        for (int t = -32; t <= 28; t++) begin
            in_valid = 1'b1;
            in_total = 6'(t);
            tick();
            in_valid = 1'b0;
            sum   = 0;
            beats = 0;
            guard = 0;
            while (!done && guard < 12) begin
                if (out_valid) begin
                    nv = int'(out_nib);
                    chk("sb_range", (nv >= -8 && nv <= 7) ? 1 : 0, 1);
                    sum += nv;
                    beats++;
                end
                tick();
                guard++;
            end
            chk("sb_done", int'(done), 1);
            chk("sb_sum", sum, t);
            chk("sb_beats", beats, 4);
            chk("sb_bundle_sum", int'(nib_a) + int'(nib_b) + int'(nib_c) + int'(nib_d), t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
